// File: rtl/window_3x3_buffer.sv
// ---------------------------------------------------------------------------
// window_3x3_buffer
//   Turns a raster pixel stream into 3x3 neighbourhood windows for the
//   convolution / edge-detect stage. Two line buffers keep the previous two
//   rows and a 3x3 shift window slides across the current row. Only interior
//   centres are emitted: (n_rows-2)*(n_columns-2) windows per frame.
//
// Ports
//   clk          clock, rising edge
//   n_rst        synchronous active-low reset
//   frame_start  1-cycle pulse: latch geometry, (re)start a frame
//   n_columns    pixels per row, sampled on frame_start
//   n_rows       rows per frame, sampled on frame_start
//   pix_valid    pix_data valid this cycle
//   pix_data     incoming pixel, raster order
//   pix_ready    block accepts a pixel (only while a frame is active)
//   win_valid    1-cycle pulse: win_data/win_col/win_row hold a new window
//   win_data     p[i][j] at [(3*i+j)*DATA_W +: DATA_W], i=row (0=top), j=col (0=left)
//   win_col      centre column of the window (0-based)
//   win_row      centre row of the window (0-based)
//   frame_done   sticky, set with the final window, cleared by frame_start
//   cfg_err      sticky, bad geometry at frame_start, cleared by a good one
// ---------------------------------------------------------------------------
module window_3x3_buffer #(
    parameter int DATA_W   = 8,
    parameter int MAX_COLS = 640
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                frame_start,
    input  logic [15:0]         n_columns,
    input  logic [15:0]         n_rows,
    input  logic                pix_valid,
    input  logic [DATA_W-1:0]   pix_data,
    output logic                pix_ready,
    output logic                win_valid,
    output logic [9*DATA_W-1:0] win_data,
    output logic [15:0]         win_col,
    output logic [15:0]         win_row,
    output logic                frame_done,
    output logic                cfg_err
);

    localparam int AW = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    state_t              state;
    logic [15:0]         cols_q;
    logic [15:0]         rows_q;
    logic [15:0]         col;
    logic [15:0]         row;

    // lb1 holds row r-2, lb0 holds row r-1 (indexed by column)
    logic [DATA_W-1:0]   lb0 [MAX_COLS];
    logic [DATA_W-1:0]   lb1 [MAX_COLS];
    logic [DATA_W-1:0]   lb0_rd;
    logic [DATA_W-1:0]   lb1_rd;
    logic [AW-1:0]       col_idx;

    logic [9*DATA_W-1:0] win_q;
    logic [9*DATA_W-1:0] win_next;

    logic accept;
    logic bad_geom;
    logic last_col;
    logic last_pix;
    logic emit;

    assign pix_ready = (state == ACTIVE);

    // frame_start takes priority over a coincident pixel
    assign accept   = pix_valid && pix_ready && !frame_start;
    assign bad_geom = (n_columns < 16'd3) || (n_columns > 16'(MAX_COLS)) || (n_rows < 16'd3);

    // Geometry checks bound col below MAX_COLS, so the low bits index safely
    assign col_idx  = col[AW-1:0];
    assign lb0_rd   = lb0[col_idx];
    assign lb1_rd   = lb1[col_idx];

    assign last_col = (col == cols_q - 16'd1);
    assign last_pix = last_col && (row == rows_q - 16'd1);

    // Stale columns left over from the previous row sit in the window for the
    // first two pixels of a row; requiring col>=2 keeps them from being emitted
    assign emit     = (row >= 16'd2) && (col >= 16'd2);

    // Window shifted one column left, new right column = {row r-2, row r-1, P}
    always_comb begin
        // NOTE: default-assign everything first so no path leaves win_next unassigned (no latch).
        win_next = win_q;
        for (int i = 0; i < 3; i++) begin
            win_next[(3*i)*DATA_W   +: DATA_W] = win_q[(3*i+1)*DATA_W +: DATA_W];
            win_next[(3*i+1)*DATA_W +: DATA_W] = win_q[(3*i+2)*DATA_W +: DATA_W];
        end
        win_next[2*DATA_W +: DATA_W] = lb1_rd;
        win_next[5*DATA_W +: DATA_W] = lb0_rd;
        win_next[8*DATA_W +: DATA_W] = pix_data;
    end

    // NOTE: line buffers and the shift window carry no reset; their contents are
    // always overwritten before they can reach an emitted window, and a reset
    // would prevent mapping the buffers onto RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_idx] <= lb0_rd;
            lb0[col_idx] <= pix_data;
            win_q        <= win_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            cols_q     <= '0;
            rows_q     <= '0;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            if (frame_start) begin
                cols_q     <= n_columns;
                rows_q     <= n_rows;
                col        <= '0;
                row        <= '0;
                frame_done <= 1'b0;
                cfg_err    <= bad_geom;
                state      <= bad_geom ? IDLE : ACTIVE;
            end else if (accept) begin
                if (emit) begin
                    win_valid <= 1'b1;
                    win_data  <= win_next;
                    win_col   <= col - 16'd1;
                    win_row   <= row - 16'd1;
                end
                if (last_col) begin
                    col <= '0;
                    row <= row + 16'd1;
                end else begin
                    col <= col + 16'd1;
                end
                if (last_pix) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule
